// File: rtl/pipeline_drain_buffer.sv
// pipeline_drain_buffer
// First-word-fall-through FIFO that absorbs results from a fixed-latency MAC
// pipeline. The returned clock enable freezes the pipeline whenever a new
// result could not be stored. Pops are counted, and a result presented
// against a full, non-draining FIFO raises a sticky error flag.
module pipeline_drain_buffer #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         aclr,
    input  logic                         clr,
    input  logic                         res_valid,
    input  logic [DW-1:0]                res_data,
    output logic                         pipe_en,
    output logic                         out_valid,
    output logic [DW-1:0]                out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [15:0]                  result_count,
    output logic                         ovf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          push;
    logic          pop;

    // A word leaving the FIFO frees a slot in the same cycle, so a full FIFO
    // that is being drained can still let the pipeline advance. A flush always
    // freezes the pipeline. While in reset the pipeline is allowed to run.
    assign full      = (level == FULL_LEVEL);
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    assign pipe_en   = aclr | (~clr & (~full | pop));
    assign push      = res_valid & pipe_en;
    assign out_data  = mem[rd_ptr];

    // Storage is left without reset; only the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= res_data;
        end
    end

    // Pointer, occupancy, pop counter and sticky overflow flag bookkeeping.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            result_count <= '0;
            ovf_err      <= 1'b0;
        end else if (clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            result_count <= '0;
            ovf_err      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                result_count <= result_count + 16'd1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (res_valid && full && !pop) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_drain_buffer.sv
// tb_pipeline_drain_buffer
// Directed vector table for the single-cycle behaviour, plus hand-written
// sequences for ordering across pointer wrap, async reset and counter wrap.
module tb_pipeline_drain_buffer;

    logic        clk;
    logic        aclr;
    logic        clr;
    logic        res_valid;
    logic [31:0] res_data;
    logic        pipe_en;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [2:0]  level;
    logic [15:0] result_count;
    logic        ovf_err;

    int checks;
    int failures;

    typedef struct {
        logic        clr;
        logic        rv;
        logic [31:0] rd;
        logic        ordy;
        logic        pe;
        logic [2:0]  lvl;
        logic        ov;
        logic [31:0] data;
        logic [15:0] cnt;
        logic        ovf;
    } vec_t;

    vec_t vecs[13];

    pipeline_drain_buffer #(.DW(32), .DEPTH(4)) dut (
        .clk          (clk),
        .aclr         (aclr),
        .clr          (clr),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .pipe_en      (pipe_en),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .level        (level),
        .result_count (result_count),
        .ovf_err      (ovf_err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic c, input logic v, input logic [31:0] d, input logic r);
        clr       = c;
        res_valid = v;
        res_data  = d;
        out_ready = r;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Main stimulus sequence.
    initial begin
        int sent;
        int got;
        int mlevel;
        logic mpop;
        logic mpe;
        logic ordy;
        logic rv;
        logic [31:0] q[$];

        checks   = 0;
        failures = 0;
        aclr     = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

        // clr, rv, rd, ordy | pipe_en before edge | level, out_valid, out_data, count, ovf after edge
        vecs[0]  = '{1'b0, 1'b1, 32'h1,  1'b0, 1'b1, 3'd1, 1'b1, 32'h1,  16'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h2,  1'b0, 1'b1, 3'd2, 1'b1, 32'h1,  16'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h3,  1'b0, 1'b1, 3'd3, 1'b1, 32'h1,  16'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h4,  1'b0, 1'b1, 3'd4, 1'b1, 32'h1,  16'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h5,  1'b0, 1'b0, 3'd4, 1'b1, 32'h1,  16'd0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 32'hA5, 1'b1, 1'b1, 3'd4, 1'b1, 32'h2,  16'd1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 3'd3, 1'b1, 32'h3,  16'd2, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 32'h77, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0,  16'd0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h33, 1'b1, 1'b1, 3'd1, 1'b1, 32'h33, 16'd0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h44, 1'b1, 1'b1, 3'd1, 1'b1, 32'h44, 16'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 3'd1, 1'b1, 32'h44, 16'd1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 3'd0, 1'b0, 32'h0,  16'd2, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 3'd0, 1'b0, 32'h0,  16'd2, 1'b0};

        #2;
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_pipe_en", 32'(pipe_en), 32'd1);
        checkOutput("rst_count", 32'(result_count), 32'd0);
        checkOutput("rst_ovf", 32'(ovf_err), 32'd0);
        #10;
        aclr = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].clr, vecs[i].rv, vecs[i].rd, vecs[i].ordy);
            #1;
            checkOutput($sformatf("vec%0d_pipe_en", i), 32'(pipe_en), 32'(vecs[i].pe));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
            checkOutput($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            if (vecs[i].ov) begin
                checkOutput($sformatf("vec%0d_out_data", i), out_data, vecs[i].data);
            end
            checkOutput($sformatf("vec%0d_count", i), 32'(result_count), 32'(vecs[i].cnt));
            checkOutput($sformatf("vec%0d_ovf", i), 32'(ovf_err), 32'(vecs[i].ovf));
        end

        // Ordering across pointer wrap with random downstream readiness.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        sent   = 0;
        got    = 0;
        mlevel = 0;
        for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
            ordy = 1'($urandom_range(0, 1));
            mpop = (mlevel != 0) && ordy;
            mpe  = (mlevel < 4) || mpop;
            rv   = (sent < 10) && mpe;
            applyStimulus(1'b0, rv, 32'h10 + 32'(sent), ordy);
            #1;
            checkOutput("order_pipe_en", 32'(pipe_en), 32'(mpe));
            if (mpop) begin
                checkOutput("order_data", out_data, q.pop_front());
                got++;
            end
            if (rv) begin
                q.push_back(32'h10 + 32'(sent));
                sent++;
            end
            mlevel = mlevel + int'(rv) - int'(mpop);
            @(posedge clk);
            #1;
        end
        checkOutput("order_words_drained", 32'(got), 32'd10);
        checkOutput("order_result_count", 32'(result_count), 32'd10);
        checkOutput("order_ovf", 32'(ovf_err), 32'd0);

        // Async reset while holding three words with a push in flight.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 32'hC0 + 32'(i), 1'b0);
            @(posedge clk);
            #1;
        end
        checkOutput("arst_pre_level", 32'(level), 32'd3);
        applyStimulus(1'b0, 1'b1, 32'hEE, 1'b0);
        #3;
        aclr = 1'b1;
        #1;
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_level", 32'(level), 32'd0);
        checkOutput("arst_pipe_en", 32'(pipe_en), 32'd1);
        @(posedge clk);
        #4;
        checkOutput("arst_held_level", 32'(level), 32'd0);
        aclr = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h5A, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("arst_first_push_level", 32'(level), 32'd1);
        checkOutput("arst_first_push_data", out_data, 32'h5A);

        // Counter wrap: 65535 pops preset the count, one more wraps it to zero.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 32'h99, 1'b1);
        repeat (65536) @(posedge clk);
        #1;
        checkOutput("wrap_count_max", 32'(result_count), 32'hFFFF);
        checkOutput("wrap_level", 32'(level), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("wrap_count_zero", 32'(result_count), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
